// File: rtl/pulse_cdc_pkg.sv
// Shared types and helpers for the source-side pulse spacer.
// State encoding and a width helper for the gap timer.
package pulse_cdc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // Ceiling log2 of v, never less than one bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/pulse_gap_timer.sv
// Down-counter enforcing the spacing between issued pulses.
// Loads on a fire, counts down while waiting, flags zero.
module pulse_gap_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load wins over decrement; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_spacer_a.sv
// Absorbs bursty events and re-issues them as pulses spaced
// at least GAP clka cycles apart for a toggle synchroniser.
module pulse_spacer_a
   import pulse_cdc_pkg::*;
#(
   parameter int GAP   = 4,
   parameter int CNT_W = 4
) (
   input  logic             clka,
   input  logic             rsta,
   input  logic             ev_i,
   input  logic             en_i,
   input  logic             ovf_clr,
   output logic             pulse_o,
   output logic [CNT_W-1:0] pending,
   output logic             busy_o,
   output logic             ovf_o
);

   localparam int             GW    = clog2(GAP - 1);
   localparam logic [GW-1:0]  GLOAD = GW'(GAP - 2);
   localparam logic [CNT_W-1:0] PMAX = '1;

   state_e           state_q, state_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic             avail;
   logic             fire;
   logic             drop;
   logic             tmr_zero;

   // A direct event counts as available so it can be consumed in-cycle.
   assign avail = (pend_q != '0) || ev_i;
   assign fire  = (state_q == ST_IDLE) && en_i && avail;

   pulse_gap_timer #(
      .W (GW)
   ) u_gap (
      .clk        (clka),
      .rst_n      (rsta),
      .load_i     (fire),
      .load_val_i (GLOAD),
      .dec_i      (state_q == ST_WAIT),
      .zero_o     (tmr_zero)
   );

   // Two-state issue FSM: fire a one-cycle pulse, then wait out the gap.
   always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fire) begin
               pulse_d = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tmr_zero) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pending counter: an event fired in the same cycle it arrives nets to zero.
   always_comb begin
      pend_d = pend_q;
      drop   = 1'b0;
      unique case ({ev_i, fire})
         2'b10: begin
            if (pend_q == PMAX) drop = 1'b1;
            else                pend_d = pend_q + 1'b1;
         end
         2'b01:   pend_d = pend_q - 1'b1;
         default: pend_d = pend_q;
      endcase
   end

   // Sticky overflow; a new drop beats a simultaneous clear.
   always_comb begin
      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   // All state registers, synchronous active-low reset.
   always_ff @(posedge clka) begin
      if (!rsta) begin
         state_q <= ST_IDLE;
         pulse_q <= 1'b0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pulse_q <= pulse_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   assign pulse_o = pulse_q;
   assign pending = pend_q;
   assign ovf_o   = ovf_q;
   assign busy_o  = (state_q != ST_IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_pulse_spacer_a.sv
// Directed bench for pulse_spacer_a with a pulse-time scoreboard.
// Two instances: GAP=4/CNT_W=4 and GAP=2/CNT_W=2.
module tb_pulse_spacer_a;

   logic clka = 1'b0;
   logic clkb = 1'b0;
   always #5 clka = ~clka;
   always #7 clkb = ~clkb;

   logic       rsta;
   logic       ev_a, en_a, clr_a;
   logic       p_a, busy_a, ovf_a;
   logic [3:0] pend_a;
   logic       ev_b, en_b, clr_b;
   logic       p_b, busy_b, ovf_b;
   logic [1:0] pend_b;

   int checks = 0;
   int errors = 0;
   int ecnt   = 0;
   int qa[$];
   int qb[$];
   bit sb_a   = 1'b1;
   int last_a = -100;
   int last_b = -100;
   int k, s, peak, rx0;

   pulse_spacer_a #(.GAP(4), .CNT_W(4)) dut_a (
      .clka    (clka),
      .rsta    (rsta),
      .ev_i    (ev_a),
      .en_i    (en_a),
      .ovf_clr (clr_a),
      .pulse_o (p_a),
      .pending (pend_a),
      .busy_o  (busy_a),
      .ovf_o   (ovf_a)
   );

   pulse_spacer_a #(.GAP(2), .CNT_W(2)) dut_b (
      .clka    (clka),
      .rsta    (rsta),
      .ev_i    (ev_b),
      .en_i    (en_b),
      .ovf_clr (clr_b),
      .pulse_o (p_b),
      .pending (pend_b),
      .busy_o  (busy_b),
      .ovf_o   (ovf_b)
   );

   // receive side: toggle, 2-flop sync, edge detect in clkb
   logic       tog = 1'b0;
   logic [2:0] sy  = 3'b000;
   int         rx_cnt = 0;
   always @(posedge clka) if (p_a === 1'b1) tog <= ~tog;
   always @(posedge clkb) sy <= {sy[1:0], tog};
   always @(posedge clkb) if (sy[2] ^ sy[1]) rx_cnt <= rx_cnt + 1;

   always @(posedge clka) ecnt <= ecnt + 1;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clka);
         #1;
      end
   endtask

   always @(negedge clka) begin
      if (p_a === 1'b1) begin
         chk("gap_a", 32'(ecnt - last_a >= 4), 1);
         last_a = ecnt;
         if (sb_a) begin
            if (qa.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL pulse_a: observed pulse at edge %0d expected none", ecnt);
            end else begin
               chk("pulse_a_time", ecnt, qa.pop_front());
            end
         end
      end
   end

   always @(negedge clka) begin
      if (p_b === 1'b1) begin
         chk("gap_b", 32'(ecnt - last_b >= 2), 1);
         last_b = ecnt;
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL pulse_b: observed pulse at edge %0d expected none", ecnt);
         end else begin
            chk("pulse_b_time", ecnt, qb.pop_front());
         end
      end
   end

   initial begin
      rsta = 1'b0;
      ev_a = 0; en_a = 0; clr_a = 0;
      ev_b = 0; en_b = 0; clr_b = 0;
      step(2);
      chk("rst_p_a", p_a, 0);
      chk("rst_pend_a", pend_a, 0);
      chk("rst_ovf_a", ovf_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_p_b", p_b, 0);
      chk("rst_pend_b", pend_b, 0);
      chk("rst_ovf_b", ovf_b, 0);
      chk("rst_busy_b", busy_b, 0);
      rsta = 1'b1;
      step(1);

      // single event
      en_a = 1;
      k = ecnt + 1;
      qa.push_back(k);
      ev_a = 1;
      step(1);
      ev_a = 0;
      chk("single_pulse", p_a, 1);
      chk("single_pend", pend_a, 0);
      step(1);
      chk("single_width", p_a, 0);
      step(1);
      chk("single_busy_hi", busy_a, 1);
      step(1);
      chk("single_busy_lo", busy_a, 0);
      step(2);

      // burst of five
      k = ecnt + 1;
      for (int i = 0; i < 5; i++) qa.push_back(k + 4 * i);
      peak = 0;
      ev_a = 1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (int'(pend_a) > peak) peak = int'(pend_a);
      end
      ev_a = 0;
      for (int i = 0; i < 14; i++) begin
         step(1);
         if (int'(pend_a) > peak) peak = int'(pend_a);
      end
      chk("burst_peak", peak, 3);
      chk("burst_busy_hi", busy_a, 1);
      step(1);
      chk("burst_busy_lo", busy_a, 0);
      chk("burst_pend", pend_a, 0);
      step(2);

      // reset while waiting with events pending
      k = ecnt + 1;
      qa.push_back(k);
      qa.push_back(k + 4);
      ev_a = 1;
      step(5);
      ev_a = 0;
      chk("mid_pend", pend_a, 3);
      chk("mid_busy", busy_a, 1);
      rsta = 1'b0;
      step(1);
      chk("mid_rst_pend", pend_a, 0);
      chk("mid_rst_ovf", ovf_a, 0);
      chk("mid_rst_p", p_a, 0);
      chk("mid_rst_busy", busy_a, 0);
      rsta = 1'b1;
      step(1);
      chk("mid_post_p", p_a, 0);
      step(1);
      chk("mid_post_pend", pend_a, 0);

      // saturation on small instance
      en_b = 0;
      ev_b = 1;
      step(5);
      ev_b = 0;
      chk("sat_pend", pend_b, 3);
      chk("sat_ovf", ovf_b, 1);
      chk("sat_busy", busy_b, 1);
      k = ecnt + 1;
      qb.push_back(k);
      qb.push_back(k + 2);
      qb.push_back(k + 4);
      en_b = 1;
      step(8);
      chk("sat_drain_pend", pend_b, 0);
      chk("sat_drain_busy", busy_b, 0);
      chk("sat_ovf_kept", ovf_b, 1);
      clr_b = 1;
      step(1);
      clr_b = 0;
      chk("sat_ovf_clr", ovf_b, 0);

      // continuous events at GAP=2
      s = ecnt;
      for (int i = 0; i < 5; i++) qb.push_back(s + 1 + 2 * i);
      ev_b = 1;
      step(2);
      chk("cont_pend1", pend_b, 1);
      step(2);
      chk("cont_pend2", pend_b, 2);
      step(2);
      chk("cont_pend3", pend_b, 3);
      chk("cont_ovf0", ovf_b, 0);
      step(2);
      chk("cont_pend_sat", pend_b, 3);
      chk("cont_ovf1", ovf_b, 1);
      clr_b = 1;
      step(1);
      chk("cont_clr_fire", ovf_b, 0);
      step(1);
      chk("cont_set_wins", ovf_b, 1);
      ev_b = 0;
      clr_b = 0;
      for (int i = 0; i < 3; i++) qb.push_back(s + 11 + 2 * i);
      step(8);
      chk("cont_pend_end", pend_b, 0);
      chk("cont_busy_end", busy_b, 0);

      // end to end through toggle synchroniser
      sb_a = 1'b0;
      rx0 = rx_cnt;
      for (int i = 0; i < 50; i++) begin
         ev_a = 1;
         step(1);
         ev_a = 0;
         step($urandom_range(2, 5));
      end
      for (int t = 0; t < 400 && busy_a; t++) step(1);
      chk("e2e_drain", busy_a, 0);
      step(10);
      chk("e2e_rx_count", rx_cnt - rx0, 50);
      chk("e2e_ovf", ovf_a, 0);

      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
